// File: rtl/alu_pkg.sv
// Shared definitions for the ALU writeback slice.
//   DW, AW  : default data and register-address widths
//   RW      : width of the retired-instruction counter
//   op_e    : 3-bit opcode encoding used by the block and its bench
package alu_pkg;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int RW = 16;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_NOP = 3'b111
  } op_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath.
//   op     : opcode (alu_pkg::op_e)
//   a, b   : operands, DW bits
//   result : DW-bit result, wrapping for ADD/SUB; 0 for NOP
//   carry  : carry-out for ADD, borrow (a < b unsigned) for SUB, 0 otherwise
module alu_core #(
  parameter int DW = alu_pkg::DW
) (
  input  alu_pkg::op_e    op,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [DW-1:0]   result,
  output logic            carry
);
  import alu_pkg::*;

  // One extra bit catches the carry on ADD and the borrow on SUB: with both
  // operands zero-extended, the top bit of a - b is set exactly when a < b.
  logic [DW:0] sum;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned, which would infer a latch.
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DW-1:0];
        carry  = sum[DW];
      end
      OP_SUB: begin
        sum    = {1'b0, a} - {1'b0, b};
        result = sum[DW-1:0];
        carry  = sum[DW];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = a << b[3:0];
      OP_SHR:  result = a >> b[3:0];
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_writeback.sv
// Single-issue ALU execute/writeback stage in front of a register file.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : instruction handshake (ready is low only in reset)
//   in_op, in_rs1/2, in_rd: opcode, source and destination registers
//   readaddr1/2, readdata1/2 : combinational register-file read port
//   w_en, writeaddr, writedata: register-file write port, one cycle after accept
//   flag_z, flag_c        : zero / carry of the last retired writing op
//   retired               : wrapping count of retired writing instructions
module alu_writeback #(
  parameter int DW = alu_pkg::DW,
  parameter int AW = alu_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [AW-1:0] in_rd,
  output logic [AW-1:0] readaddr1,
  output logic [AW-1:0] readaddr2,
  input  logic [DW-1:0] readdata1,
  input  logic [DW-1:0] readdata2,
  output logic          w_en,
  output logic [AW-1:0] writeaddr,
  output logic [DW-1:0] writedata,
  output logic          flag_z,
  output logic          flag_c,
  output logic [15:0]   retired
);
  import alu_pkg::*;

  typedef struct packed {
    logic          valid;
    op_e           op;
    logic [AW-1:0] rd;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } stage_e_t;

  stage_e_t      e_q, e_d;
  logic          flag_z_q, flag_z_d;
  logic          flag_c_q, flag_c_d;
  logic [15:0]   retired_q, retired_d;

  logic          accept;
  logic          fwd_a, fwd_b;
  logic [DW-1:0] alu_result;
  logic          alu_carry;

  alu_core #(.DW(DW)) u_core (
    .op     (e_q.op),
    .a      (e_q.a),
    .b      (e_q.b),
    .result (alu_result),
    .carry  (alu_carry)
  );

  // Read port follows the request addresses directly, valid or not.
  assign readaddr1 = in_rs1;
  assign readaddr2 = in_rs2;

  assign in_ready = ~rst;
  assign accept   = in_valid & in_ready;

  // The write is gated by rst so an op caught in flight by reset never lands.
  assign w_en      = e_q.valid && (e_q.op != OP_NOP) && !rst;
  assign writeaddr = e_q.rd;
  assign writedata = alu_result;

  // The register file only commits this cycle's write at the clock edge, so a
  // dependent instruction accepted now takes the value off the write port.
  // Gating on w_en keeps a NOP's dummy result from ever being forwarded.
  assign fwd_a = w_en && (in_rs1 == writeaddr);
  assign fwd_b = w_en && (in_rs2 == writeaddr);

  always_comb begin
    e_d.valid = accept;
    e_d.op    = op_e'(in_op);
    e_d.rd    = in_rd;
    e_d.a     = fwd_a ? writedata : readdata1;
    e_d.b     = fwd_b ? writedata : readdata2;
  end

  // Flags and the counter capture the op at the end of its write cycle, the
  // same edge at which the register file commits it.
  always_comb begin
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;
    retired_d = retired_q;
    if (w_en) begin
      flag_z_d  = (alu_result == '0);
      flag_c_d  = alu_carry;
      retired_d = retired_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    e_q       <= e_d;
    flag_z_q  <= flag_z_d;
    flag_c_q  <= flag_c_d;
    retired_q <= retired_d;
    if (rst) begin
      // NOTE: only control state is reset; the operand/opcode fields are
      // qualified by valid and never observed while it is low.
      e_q.valid <= 1'b0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
      retired_q <= '0;
    end
  end

  assign flag_z  = flag_z_q;
  assign flag_c  = flag_c_q;
  assign retired = retired_q;

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 SHALL have parameter DW, default 16: operand/result width, matching register_file data width.
REQ-002 SHALL have parameter AW, default 4: register address width (16 registers).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: instruction present.
REQ-006 SHALL have port in_ready, output, 1: block can accept an instruction.
REQ-007 SHALL have port in_op, input, 3: opcode.
REQ-008 SHALL have ports in_rs1, in_rs2 and in_rd, each input, AW: source and destination registers.
REQ-009 SHALL have ports readaddr1 and readaddr2, each output, AW: read addresses to register_file.
REQ-010 SHALL have ports readdata1 and readdata2, each input, DW: combinational read data from register_file.
REQ-011 SHALL have ports w_en (output, 1), writeaddr (output, AW) and writedata (output, DW): register_file write port.
REQ-012 SHALL have ports flag_z and flag_c, each output, 1: zero and carry of the last retired op.
REQ-013 SHALL have port retired, output, 16: count of retired writing instructions.

Function
REQ-014 SHALL drive readaddr1=in_rs1 and readaddr2=in_rs2 combinationally, regardless of in_valid.
REQ-015 SHALL set in_ready=0 while rst=1, and 1 otherwise; an instruction is accepted on a cycle with in_valid & in_ready.
REQ-016 SHALL latch op, rd and both operands on accept (stage E valid), and clear stage E valid on a cycle without accept.
REQ-017 SHALL decode opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL by b[3:0], 110 SHR (logical) by b[3:0], 111 NOP (no write).
REQ-018 SHALL use DW-bit wrap-around for ADD/SUB; carry = carry-out for ADD, borrow (a<b unsigned) for SUB, 0 for all other ops.
REQ-019 SHALL, when stage E is valid and the op is not NOP, assert w_en=1 with writeaddr=rd and writedata=result in the cycle after accept; latency is 1 cycle accept-to-write, and the register file commits at the end of that cycle.
REQ-020 SHALL hold w_en=0 in every other cycle; writeaddr/writedata are don't-care when w_en=0.
REQ-021 SHALL forward: if an accept coincides with w_en=1 and in_rs1==writeaddr, operand a = writedata instead of readdata1; likewise for in_rs2/operand b; both may forward simultaneously.
REQ-022 SHALL NOT forward when the in-flight op is NOP (w_en=0).
REQ-023 SHALL update flag_z (result==0) and flag_c on the write cycle of each non-NOP op; NOP leaves the flags unchanged.
REQ-024 SHALL increment retired on each w_en=1 cycle, wrapping from 0xFFFF to 0x0000.
REQ-025 SHALL sustain back-to-back accepts at one instruction per cycle with no bubbles.

Reset
REQ-026 SHALL clear stage E valid, w_en, flag_z, flag_c and retired to 0 while rst=1.
REQ-027 SHALL discard an in-flight op when rst is asserted mid-operation: no write occurs in the cycle after the reset cycle.
REQ-028 SHALL accept no instruction in the reset cycle; the first accept is possible in the first cycle with rst=0.

Structure
REQ-029 SHALL place opcode constants, DW and AW in a shared package alu_pkg, used by the block and its bench.
REQ-030 SHALL implement the combinational datapath (result, carry) as sub-module alu_core; the pipeline registers, forwarding and counter sit in alu_writeback.

Verification
REQ-031 SHALL cover basic ADD: bench register_file with R3=0x0005 and R4=0x0007, ADD rd=5 rs1=3 rs2=4 -> next cycle w_en=1, writeaddr=5, writedata=0x000C, flag_z=0, retired=1.
REQ-032 SHALL cover forwarding: back-to-back ADD R5=R3+R4 then SUB R6=R5-R3 -> second write R6=0x0007 (forwarded 0x000C), not the stale R5 value.
REQ-033 SHALL cover wrap and carry: ADD with 0xFFFF+0x0001 -> writedata=0x0000, flag_z=1, flag_c=1; SUB 0x0000-0x0001 -> 0xFFFF, flag_c=1.
REQ-034 SHALL cover NOP: accept op 111 -> w_en stays 0, retired and flags unchanged, no forwarding to the following instruction.
REQ-035 SHALL cover reset mid-operation: accept ADD, assert rst the next cycle -> no write occurs, retired=0, in_ready=0 during reset.
REQ-036 SHALL cover counter wrap: preload via 65536 writing ops -> retired returns to 0x0000.
